seq_detect: RTL and testbench

SEQ_DETECT -- requirements
Module: seq_detect

---
 rtl/seq_detect_pkg.sv | 35 +++
 rtl/sat_counter.sv | 36 +++
 rtl/seq_detect.sv | 70 +++++++
 tb/tb_seq_detect.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared encodings and constants for the serial 1011 pattern detector.
package seq_detect_pkg;

    localparam int unsigned STATE_W   = 2;
    localparam int unsigned PATTERN_W = 4;

    localparam logic [PATTERN_W-1:0] PATTERN = 4'b1011;

    // Each state name is the length of the pattern prefix matched so far.
    typedef enum logic [STATE_W-1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } state_e;

    // Overlapping-match transition for one accepted bit.
    function automatic state_e next_state(input state_e cur, input logic bit_in);
        state_e nxt;
        nxt = S0;
        unique case (cur)
            S0: nxt = (bit_in == PATTERN[3]) ? S1 : S0;
            S1: nxt = (bit_in == PATTERN[2]) ? S2 : S1;
            S2: nxt = (bit_in == PATTERN[1]) ? S3 : S0;
            S3: nxt = (bit_in == PATTERN[0]) ? S1 : S2;
        endcase
        return nxt;
    endfunction

    // True when the accepted bit completes the pattern from the given state.
    function automatic logic completes(input state_e cur, input logic bit_in);
        return (cur == S3) && (bit_in == PATTERN[0]);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a sticky flag for increments attempted at full scale.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         ovf
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    logic at_max_c;

    assign at_max_c = (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (inc) begin
            // Hold at full scale and remember that a count was lost.
            if (at_max_c) begin
                ovf <= 1'b1;
            end else begin
                cnt <= cnt + W'(1);
            end
        end
    end

endmodule

// File: rtl/seq_detect.sv
// Serial 1011 detector with overlap, registered match pulse and saturating match count.
module seq_detect
    import seq_detect_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               din,
    input  logic               din_valid,
    input  logic               clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               ovf,
    output logic [STATE_W-1:0] state_o
);

    state_e state;
    state_e state_next;
    logic   detect_c;

    // State register; clr wins over any bit presented in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S0;
        end else if (clr) begin
            state <= S0;
        end else begin
            state <= state_next;
        end
    end

    // Next state: hold unless a qualified bit arrives.
    always_comb begin
        state_next = state;
        if (din_valid) begin
            state_next = next_state(state, din);
        end
    end

    // Detection strobe, suppressed by clr so the discarded bit neither pulses nor counts.
    always_comb begin
        detect_c = 1'b0;
        if (din_valid && !clr) begin
            detect_c = completes(state, din);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match <= 1'b0;
        end else begin
            match <= detect_c;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_sat_counter (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (detect_c),
        .clr  (clr),
        .cnt  (match_cnt),
        .ovf  (ovf)
    );

    assign state_o = state;

endmodule

// File: tb/tb_seq_detect.sv
// Directed bench for seq_detect: vector table plus saturation and async-reset sequences.
module tb_seq_detect;

    logic       clk;
    logic       rst_n;
    logic       din;
    logic       din_valid;
    logic       clr;
    logic       match;
    logic [7:0] match_cnt;
    logic       ovf;
    logic [1:0] state_o;
    logic       match2;
    logic [1:0] match_cnt2;
    logic       ovf2;
    logic [1:0] state_o2;

    int passed;
    int total;

    typedef struct {
        logic       v;
        logic       d;
        logic       c;
        logic       m;
        logic [1:0] st;
        logic [7:0] cnt;
        logic [1:0] cnt2;
    } vec_t;

    vec_t vecs[$];

    seq_detect #(.CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .din_valid(din_valid),
        .clr      (clr),
        .match    (match),
        .match_cnt(match_cnt),
        .ovf      (ovf),
        .state_o  (state_o)
    );

    seq_detect #(.CNT_W(2)) dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .din_valid(din_valid),
        .clr      (clr),
        .match    (match2),
        .match_cnt(match_cnt2),
        .ovf      (ovf2),
        .state_o  (state_o2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic v, input logic d, input logic c, input logic m,
                       input logic [1:0] st, input int cnt, input int cnt2);
        vec_t e;
        e.v    = v;
        e.d    = d;
        e.c    = c;
        e.m    = m;
        e.st   = st;
        e.cnt  = 8'(cnt);
        e.cnt2 = 2'(cnt2);
        vecs.push_back(e);
    endtask

    // Present inputs, take one edge, leave the time at edge+1 for sampling.
    task automatic step(input logic v, input logic d, input logic c);
        din_valid = v;
        din       = d;
        clr       = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        rst_n     = 1'b0;
        din       = 1'b0;
        din_valid = 1'b0;
        clr       = 1'b0;

        //     v d c  m  st cnt cnt2
        add(1, 1, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 2, 0, 0);
        add(1, 1, 0, 0, 3, 0, 0);
        add(1, 1, 0, 1, 1, 1, 1);   // first 1011
        add(1, 0, 0, 0, 2, 1, 1);
        add(1, 1, 0, 0, 3, 1, 1);
        add(1, 1, 0, 1, 1, 2, 2);   // overlapped 1011011, 3 cycles later
        add(0, 0, 0, 0, 1, 2, 2);
        add(1, 0, 0, 0, 2, 2, 2);
        add(1, 1, 0, 0, 3, 2, 2);
        add(0, 1, 0, 0, 3, 2, 2);   // invalid bits ignored
        add(0, 0, 0, 0, 3, 2, 2);
        add(0, 0, 0, 0, 3, 2, 2);
        add(1, 1, 0, 1, 1, 3, 3);
        add(1, 1, 0, 0, 1, 3, 3);
        add(1, 0, 0, 0, 2, 3, 3);
        add(1, 0, 0, 0, 0, 3, 3);
        add(1, 0, 0, 0, 0, 3, 3);
        add(1, 1, 0, 0, 1, 3, 3);
        add(1, 0, 0, 0, 2, 3, 3);
        add(1, 1, 0, 0, 3, 3, 3);
        add(1, 1, 1, 0, 0, 0, 0);   // clr beats a completing bit in S3
        add(1, 1, 0, 0, 1, 0, 0);

        // Reset state
        #12;
        check("rst_match", 16'(match), 16'd0);
        check("rst_cnt", 16'(match_cnt), 16'd0);
        check("rst_ovf", 16'(ovf), 16'd0);
        check("rst_state", 16'(state_o), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].d, vecs[i].c);
            check($sformatf("vec%0d_match", i), 16'(match), 16'(vecs[i].m));
            check($sformatf("vec%0d_state", i), 16'(state_o), 16'(vecs[i].st));
            check($sformatf("vec%0d_cnt", i), 16'(match_cnt), 16'(vecs[i].cnt));
            check($sformatf("vec%0d_cnt2", i), 16'(match_cnt2), 16'(vecs[i].cnt2));
            check($sformatf("vec%0d_ovf", i), 16'(ovf), 16'd0);
        end

        // Saturation of the 2-bit counter over five overlapped detections
        step(0, 0, 1);
        step(1, 1, 0);
        step(1, 0, 0);
        step(1, 1, 0);
        step(1, 1, 0);
        check("sat_d1_match", 16'(match2), 16'd1);
        check("sat_d1_cnt2", 16'(match_cnt2), 16'd1);
        check("sat_d1_ovf2", 16'(ovf2), 16'd0);
        for (int k = 2; k <= 5; k++) begin
            step(1, 0, 0);
            step(1, 1, 0);
            step(1, 1, 0);
            check($sformatf("sat_d%0d_match", k), 16'(match2), 16'd1);
            check($sformatf("sat_d%0d_cnt2", k), 16'(match_cnt2), 16'((k > 3) ? 3 : k));
            check($sformatf("sat_d%0d_ovf2", k), 16'(ovf2), 16'((k >= 4) ? 1 : 0));
            check($sformatf("sat_d%0d_cnt", k), 16'(match_cnt), 16'(k));
        end
        step(0, 0, 0);
        check("sat_hold_ovf2", 16'(ovf2), 16'd1);
        check("sat_hold_match", 16'(match2), 16'd0);
        step(0, 0, 1);
        check("sat_clr_cnt2", 16'(match_cnt2), 16'd0);
        check("sat_clr_ovf2", 16'(ovf2), 16'd0);
        check("sat_clr_state", 16'(state_o2), 16'd0);

        // Async reset right after a detection clears outputs before any edge
        step(1, 1, 0);
        step(1, 0, 0);
        step(1, 1, 0);
        step(1, 1, 0);
        check("pre_rst_match", 16'(match), 16'd1);
        din_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_match", 16'(match), 16'd0);
        check("arst_cnt", 16'(match_cnt), 16'd0);
        check("arst_state", 16'(state_o), 16'd0);
        #2;
        rst_n = 1'b1;

        // Partial match lost across reset
        step(1, 1, 0);
        step(1, 0, 0);
        step(1, 1, 0);
        check("mid_state", 16'(state_o), 16'd3);
        din_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_state", 16'(state_o), 16'd0);
        #2;
        rst_n = 1'b1;
        step(1, 1, 0);
        check("post_rst_match", 16'(match), 16'd0);
        check("post_rst_state", 16'(state_o), 16'd1);
        step(1, 0, 0);
        step(1, 1, 0);
        check("post_rst_3_match", 16'(match), 16'd0);
        step(1, 1, 0);
        check("post_rst_4_match", 16'(match), 16'd1);
        check("post_rst_4_cnt", 16'(match_cnt), 16'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
